// File: rtl/sha_msg_schedule.sv
// SHA-256 message schedule: streams W[t]/K[t] for t=0..63 from one 512-bit block
// using a 16-word sliding window, with a valid/ready handshake to the round stage.
module sha_msg_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block,
  input  logic         ready,
  output logic         valid,
  output logic [31:0]  W_out,
  output logic [31:0]  K_out,
  output logic [5:0]   round,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t            state, state_nxt;
  logic [15:0][31:0] win;   // win[i] = W[round+i]; win[0] is the word being offered
  logic [31:0]       w_new;
  logic              load, accept, last;

  assign load   = (state == IDLE) && start;
  assign accept = valid && ready;
  assign last   = accept && (round == 6'd63);
  // W[t+16] from W[t+14], W[t+9], W[t+1], W[t]; the adder discards carries past bit 31
  assign w_new  = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign W_out  = win[0];
  assign K_out  = K_TAB[round];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win   <= '0;
      round <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        for (int i = 0; i < 16; i++) win[i] <= block[32*(15-i) +: 32];
        round <= '0;
        valid <= 1'b1;
        busy  <= 1'b1;
      end else if (accept) begin
        win   <= {w_new, win[15:1]};
        round <= round + 6'd1;   // 63 wraps to 0 on the final handshake
        if (last) begin
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Scoreboard bench for sha_msg_schedule: an independent SHA-256 schedule model
// (K derived from prime cube roots) fills a queue, popped on each accepted round.
module tb_sha_msg_schedule;

  logic         clk = 1'b0;
  logic         rst_n, start, ready;
  logic [511:0] block;
  logic         valid, busy, done;
  logic [31:0]  W_out, K_out;
  logic [5:0]   round;

  sha_msg_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block(block), .ready(ready),
    .valid(valid), .W_out(W_out), .K_out(K_out), .round(round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] w; logic [31:0] k; logic [5:0] r; } exp_t;
  exp_t         sb[$];
  logic [31:0]  kt [64];
  logic [31:0]  obs_w [64];
  logic [31:0]  obs_k [64];
  logic [511:0] abc_blk, junk_blk;
  int           total = 0, bad = 0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] kcalc(input int p);
    logic [127:0] tgt, r, c;
    tgt = 128'(p) << 96;
    r   = '0;
    for (int b = 36; b >= 0; b--) begin
      c = r | (128'(1) << b);
      if (c * c * c <= tgt) r = c;
    end
    return r[31:0];
  endfunction

  task automatic push_block(input logic [511:0] b);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = b[32*(15-t) +: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.w = w[t]; e.k = kt[t]; e.r = 6'(t);
      sb.push_back(e);
    end
  endtask

  // Runs until the scoreboard drains; checks handshake, stability, gaps and the done pulse.
  task automatic run_stream(input bit rand_ready, input bit hold_start,
                            input logic [511:0] next_blk, input int nblk);
    int   cyc = 0, n_valid = 0, n_done = 0, n_gap = 0;
    bit   held = 0, seen = 0;
    logic [31:0] pw = '0, pk = '0;
    logic [5:0]  pr = '0;
    exp_t e;
    while (sb.size() > 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = hold_start;
      ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (done) n_done++;
      if (cyc == 1) begin
        total++;
        if (valid !== 1'b1) begin bad++; $display("FAIL start_latency valid=%b want 1", valid); end
      end
      if (valid) begin
        n_valid++; seen = 1;
        block = (n_done > 0) ? junk_blk : next_blk;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_run busy=%b want 1", busy); end
        if (held) begin
          total++;
          if (W_out !== pw || K_out !== pk || round !== pr) begin
            bad++;
            $display("FAIL stall_hold W=%h K=%h r=%0d want W=%h K=%h r=%0d", W_out, K_out, round, pw, pk, pr);
          end
        end
        if (ready) begin
          e = sb.pop_front();
          total++;
          if (W_out !== e.w || K_out !== e.k || round !== e.r) begin
            bad++;
            $display("FAIL round_out W=%h K=%h r=%0d want W=%h K=%h r=%0d", W_out, K_out, round, e.w, e.k, e.r);
          end
          obs_w[e.r] = W_out; obs_k[e.r] = K_out;
        end
      end else if (seen) n_gap++;
      held = valid && !ready;
      pw = W_out; pk = K_out; pr = round;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL stream_timeout left=%0d want 0", sb.size());
      sb.delete();
    end
    total++;
    if (n_gap != nblk - 1 || n_done != nblk - 1) begin
      bad++;
      $display("FAIL stream_gaps gaps=%0d dones=%0d want %0d", n_gap, n_done, nblk - 1);
    end
    if (!rand_ready) begin
      total++;
      if (n_valid != 64 * nblk) begin bad++; $display("FAIL valid_count got=%0d want %0d", n_valid, 64 * nblk); end
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || round !== 6'd0) begin
      bad++;
      $display("FAIL done_cycle done=%b valid=%b busy=%b r=%0d want 1 0 0 0", done, valid, busy, round);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse done=%b valid=%b want 0 0", done, valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; ready = 1'b1; block = junk_blk;
    #3;
    total++;
    if ({valid, busy, done, round, W_out} !== '0) begin
      bad++;
      $display("FAIL reset_state v=%b b=%b d=%b r=%0d W=%h want all 0", valid, busy, done, round, W_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_abc();
    start = 1'b1; block = abc_blk;
    push_block(abc_blk);
    run_stream(1'b0, 1'b0, junk_blk, 1);
    total++;
    if (obs_w[0] !== 32'h61626380 || obs_w[15] !== 32'h00000018) begin
      bad++; $display("FAIL abc_w0_w15 got=%h %h want 61626380 00000018", obs_w[0], obs_w[15]);
    end
    total++;
    if (obs_w[16] !== 32'h61626380 || obs_w[17] !== 32'h000F0000 || obs_w[18] !== 32'h7DA86405) begin
      bad++; $display("FAIL abc_w16_18 got=%h %h %h want 61626380 000f0000 7da86405", obs_w[16], obs_w[17], obs_w[18]);
    end
    total++;
    if (obs_k[0] !== 32'h428A2F98 || obs_k[63] !== 32'hC67178F2) begin
      bad++; $display("FAIL abc_k0_k63 got=%h %h want 428a2f98 c67178f2", obs_k[0], obs_k[63]);
    end
  endtask

  task automatic test_ready_toggle();
    start = 1'b1; block = abc_blk;
    push_block(abc_blk);
    run_stream(1'b1, 1'b0, junk_blk, 1);
  endtask

  task automatic test_back_to_back();
    logic [511:0] b2;
    for (int i = 0; i < 16; i++) b2[32*i +: 32] = $urandom();
    start = 1'b1; block = abc_blk;
    push_block(abc_blk);
    push_block(b2);
    run_stream(1'b0, 1'b1, b2, 2);
  endtask

  task automatic test_reset_mid();
    logic [511:0] b;
    int cyc = 0;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    start = 1'b1; block = b; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(valid && round == 6'd30) && cyc < 200) begin @(negedge clk); cyc++; end
    total++;
    if (cyc >= 200) begin bad++; $display("FAIL reach_round30 r=%0d want 30", round); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({valid, busy, done, round, W_out} !== '0) begin
      bad++;
      $display("FAIL async_reset v=%b b=%b d=%b r=%0d W=%h want all 0", valid, busy, done, round, W_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL post_reset_idle valid=%b busy=%b want 0 0", valid, busy);
      end
    end
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    start = 1'b1; block = b;
    push_block(b);
    run_stream(1'b0, 1'b0, junk_blk, 1);
  endtask

  task automatic test_all_ones();
    start = 1'b1; block = '1;
    push_block('1);
    run_stream(1'b1, 1'b0, junk_blk, 1);
  endtask

  initial begin
    int p = 2, n = 0;
    bit prime;
    while (n < 64) begin
      prime = 1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) prime = 0;
      if (prime) begin kt[n] = kcalc(p); n++; end
      p++;
    end
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    junk_blk = {16{32'hDEADBEEF}};

    test_reset();
    test_abc();
    test_ready_toggle();
    test_back_to_back();
    test_reset_mid();
    test_all_ones();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
